// File: rtl/accel_pkg.sv
// accel_pkg: constants and types shared by the ADXL362 reader.
//   - ADXL362 command bytes, register addresses and the POWER_CTL value
//   - MID_SCALE: offset-binary value that means "level"
//   - state_t: top-level sequencer states; phase_t: chip-select phases
//   - to_offset_binary(): 12-bit two's complement axis -> 9-bit offset binary
package accel_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;
  localparam logic [8:0] MID_SCALE     = 9'd256;

  // Index of the final byte in each transaction type.
  localparam logic [2:0] LAST_INIT_IDX = 3'd2;
  localparam logic [2:0] LAST_READ_IDX = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_CONVERT
  } state_t;

  // PH_OFF: chip select high; PH_BYTES: shifting; PH_HOLD: CS hold after last edge.
  typedef enum logic [1:0] {
    PH_OFF,
    PH_BYTES,
    PH_HOLD
  } phase_t;

  // H[7:4] is sign extension on the sensor and is ignored; divide by 8 and
  // flip the sign bit to get 0..511 centred on 256.
  function automatic logic [8:0] to_offset_binary(input logic [7:0] lo,
                                                  input logic [7:0] hi);
    logic [11:0] s12;
    s12 = {hi[3:0], lo};
    return {~s12[11], s12[10:3]};
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: transfers one byte as an SPI mode-0 master.
//   clk, reset        : system clock, asynchronous active-high reset
//   start             : begin a byte (ignored while a byte is in progress)
//   tx_byte[7:0]      : byte to send, MSB first
//   miso              : serial data from the slave
//   sclk, mosi        : SPI clock (idles low) and serial data to the slave
//   rx_byte[7:0]      : byte received, valid when done pulses
//   done              : one-clock pulse after the eighth falling SCLK edge
// Each SCLK level lasts HALF clocks. MOSI is updated on the same clk edge that
// drives SCLK low, and MISO is captured on the edge that drives SCLK high.
module spi_byte_shifter #(
  parameter int unsigned HALF = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  logic        r_active;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_done;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit;
  logic [6:0]  r_tx;
  logic [7:0]  r_rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (start) begin
          r_active <= 1'b1;
          r_mosi   <= tx_byte[7];
          r_tx     <= tx_byte[6:0];
          r_cnt    <= '0;
          r_bit    <= '0;
        end
      end else if (r_cnt == HALF - 1) begin
        r_cnt <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], miso};
        end else begin
          r_sclk <= 1'b0;
          if (r_bit == 3'd7) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_mosi   <= 1'b0;
          end else begin
            r_bit  <= r_bit + 3'd1;
            r_mosi <= r_tx[6];
            r_tx   <= {r_tx[5:0], 1'b0};
          end
        end
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign rx_byte = r_rx;
  assign done    = r_done;

endmodule

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: ADXL362 SPI master producing 9-bit offset-binary tilt.
//   clk, reset           : system clock, asynchronous active-high reset
//   spi_sclk/mosi/cs_n   : SPI master outputs (mode 0)
//   spi_miso             : SPI slave data in
//   accel_x, accel_y     : tilt per axis, 256 = level
//   sample_valid         : one-clock pulse when accel_x/accel_y update
//   busy                 : high while spi_cs_n is low
// After reset a POWER_CTL write enables measurement; then every sample tick a
// six-byte burst read fetches XL, XH, YL, YH which are converted together.
module accel_spi_reader #(
  parameter int unsigned CLK_FREQUENCY_HZ    = 100000000,
  parameter int unsigned SCLK_FREQUENCY_HZ   = 1000000,
  parameter int unsigned SAMPLE_FREQUENCY_HZ = 100,
  parameter int unsigned SIMULATE            = 0,
  parameter int unsigned SIMULATE_SAMPLE_CNT = 2000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic [8:0] accel_x,
  output logic [8:0] accel_y,
  output logic       sample_valid,
  output logic       busy
);
  import accel_pkg::*;

  localparam int unsigned HALF     = CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ);
  localparam int unsigned TICK_MAX = (SIMULATE != 0) ? SIMULATE_SAMPLE_CNT
                                   : CLK_FREQUENCY_HZ / SAMPLE_FREQUENCY_HZ - 1;
  // Loaded on CS rise; a new transaction may start once it reaches zero,
  // giving exactly 2*HALF clocks of CS high.
  localparam int unsigned GAP_LOAD = 2 * HALF - 1;

  state_t      r_state;
  phase_t      r_phase;
  logic        r_cs_n;
  logic        r_start;
  logic [7:0]  r_tx_byte;
  logic [2:0]  r_idx;
  logic [31:0] r_hcnt;
  logic [31:0] r_gap;
  logic [31:0] r_tick_cnt;
  logic        r_tick;
  logic        r_pending;
  logic [7:0]  r_xl;
  logic [7:0]  r_xh;
  logic [7:0]  r_yl;
  logic [7:0]  r_yh;
  logic [8:0]  r_accel_x;
  logic [8:0]  r_accel_y;
  logic        r_valid;

  logic        w_sh_sclk;
  logic        w_sh_mosi;
  logic [7:0]  w_sh_rx;
  logic        w_sh_done;
  logic [2:0]  w_last_idx;

  function automatic logic [7:0] byte_for(input state_t st, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (st == ST_INIT) begin
      case (idx)
        3'd0:    b = CMD_WRITE;
        3'd1:    b = REG_POWER_CTL;
        3'd2:    b = PWR_MEASURE;
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    b = CMD_READ;
        3'd1:    b = REG_XDATA_L;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign w_last_idx = (r_state == ST_INIT) ? LAST_INIT_IDX : LAST_READ_IDX;

  spi_byte_shifter #(
    .HALF (HALF)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (r_start),
    .tx_byte (r_tx_byte),
    .miso    (spi_miso),
    .sclk    (w_sh_sclk),
    .mosi    (w_sh_mosi),
    .rx_byte (w_sh_rx),
    .done    (w_sh_done)
  );

  // Free-running sample tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TICK_MAX) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 32'd1;
      r_tick     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_phase   <= PH_OFF;
      r_cs_n    <= 1'b1;
      r_start   <= 1'b0;
      r_tx_byte <= '0;
      r_idx     <= '0;
      r_hcnt    <= '0;
      r_gap     <= '0;
      r_pending <= 1'b0;
      r_xl      <= '0;
      r_xh      <= '0;
      r_yl      <= '0;
      r_yh      <= '0;
      r_accel_x <= MID_SCALE;
      r_accel_y <= MID_SCALE;
      r_valid   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_valid <= 1'b0;
      if (r_gap != '0) r_gap <= r_gap - 32'd1;
      // Ticks outside IDLE are remembered; IDLE clears this when it consumes one.
      if (r_tick) r_pending <= 1'b1;

      case (r_state)
        ST_INIT, ST_READ: begin
          case (r_phase)
            PH_OFF: begin
              if (r_gap == '0) begin
                r_cs_n    <= 1'b0;
                r_start   <= 1'b1;
                r_tx_byte <= byte_for(r_state, 3'd0);
                r_idx     <= '0;
                r_phase   <= PH_BYTES;
              end
            end
            PH_BYTES: begin
              if (w_sh_done) begin
                if (r_state == ST_READ) begin
                  case (r_idx)
                    3'd2:    r_xl <= w_sh_rx;
                    3'd3:    r_xh <= w_sh_rx;
                    3'd4:    r_yl <= w_sh_rx;
                    3'd5:    r_yh <= w_sh_rx;
                    default: ;
                  endcase
                end
                if (r_idx == w_last_idx) begin
                  r_phase <= PH_HOLD;
                  r_hcnt  <= '0;
                end else begin
                  r_idx     <= r_idx + 3'd1;
                  r_tx_byte <= byte_for(r_state, r_idx + 3'd1);
                  r_start   <= 1'b1;
                end
              end
            end
            PH_HOLD: begin
              if (r_hcnt == HALF - 1) begin
                r_cs_n  <= 1'b1;
                r_gap   <= GAP_LOAD;
                r_phase <= PH_OFF;
                r_state <= (r_state == ST_INIT) ? ST_IDLE : ST_CONVERT;
              end else begin
                r_hcnt <= r_hcnt + 32'd1;
              end
            end
            default: r_phase <= PH_OFF;
          endcase
        end
        ST_IDLE: begin
          if (r_pending || r_tick) begin
            r_pending <= 1'b0;
            r_state   <= ST_READ;
          end
        end
        ST_CONVERT: begin
          r_accel_x <= to_offset_binary(r_xl, r_xh);
          r_accel_y <= to_offset_binary(r_yl, r_yh);
          r_valid   <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign spi_sclk     = w_sh_sclk;
  assign spi_mosi     = w_sh_mosi;
  assign spi_cs_n     = r_cs_n;
  assign busy         = ~r_cs_n;
  assign accel_x      = r_accel_x;
  assign accel_y      = r_accel_y;
  assign sample_valid = r_valid;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: an ADXL362-like slave answers burst reads from a
// response table; a second instance with a very short sample period exercises
// tick queuing and the chip-select gap.
module tb_accel_spi_reader;

  localparam int HALF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_b = 1'b1;

  logic       spi_sclk, spi_mosi, spi_cs_n, sample_valid, busy;
  logic       spi_miso = 1'b0;
  logic [8:0] accel_x, accel_y;

  logic       b_sclk, b_mosi, b_cs_n, b_valid, b_busy;
  logic       b_miso = 1'b0;
  logic [8:0] b_ax, b_ay;

  always #5 clk = ~clk;

  accel_spi_reader #(
    .CLK_FREQUENCY_HZ    (100000000),
    .SCLK_FREQUENCY_HZ   (25000000),
    .SAMPLE_FREQUENCY_HZ (100),
    .SIMULATE            (1),
    .SIMULATE_SAMPLE_CNT (300)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs_n     (spi_cs_n),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  accel_spi_reader #(
    .CLK_FREQUENCY_HZ    (100000000),
    .SCLK_FREQUENCY_HZ   (25000000),
    .SAMPLE_FREQUENCY_HZ (100),
    .SIMULATE            (1),
    .SIMULATE_SAMPLE_CNT (40)
  ) dut_fast (
    .clk          (clk),
    .reset        (rst_b),
    .spi_sclk     (b_sclk),
    .spi_mosi     (b_mosi),
    .spi_miso     (b_miso),
    .spi_cs_n     (b_cs_n),
    .accel_x      (b_ax),
    .accel_y      (b_ay),
    .sample_valid (b_valid),
    .busy         (b_busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- slave model and protocol monitor (main instance) -------
  typedef struct { logic [47:0] bits; int nrise; } txn_t;
  txn_t        txq[$];
  logic [7:0]  resp [6];
  logic        m_prev_cs = 1'b1, m_prev_sclk = 1'b0, m_prev_mosi = 1'b0;
  logic [47:0] m_bits = '0;
  int          m_nrise = 0;
  int          m_since_mosi = 1000, m_since_csfall = 1000, m_since_fall = 1000;
  int          m_since_csrise = 1000;
  int          m_min_lead = 1000, m_min_lag = 1000, m_min_setup = 1000;
  int          m_mosi_err = 0, m_sclk_err = 0, m_busy_err = 0;
  int          m_nvalid = 0, m_last_lat = -1;

  function automatic logic resp_bit(input int n);
    logic [7:0] b;
    if (n >= 48) return 1'b0;
    b = resp[n / 8];
    return b[7 - (n % 8)];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_prev_cs      = spi_cs_n;
      m_prev_sclk    = spi_sclk;
      m_prev_mosi    = spi_mosi;
      m_bits         = '0;
      m_nrise        = 0;
      m_since_mosi   = 1000;
      m_since_csfall = 1000;
      m_since_fall   = 1000;
      m_since_csrise = 1000;
      spi_miso       = 1'b0;
    end else begin
      if (busy !== ~spi_cs_n) m_busy_err++;
      if (spi_mosi !== m_prev_mosi) begin
        m_since_mosi = 0;
        if (spi_sclk) m_mosi_err++;
      end else m_since_mosi++;
      m_since_csfall++;
      m_since_fall++;
      m_since_csrise++;
      if (m_prev_cs && !spi_cs_n) begin
        m_since_csfall = 0;
        m_bits         = '0;
        m_nrise        = 0;
        spi_miso       = resp_bit(0);
      end
      if (spi_sclk && !m_prev_sclk) begin
        if (spi_cs_n) m_sclk_err++;
        else begin
          if (m_nrise == 0 && m_since_csfall < m_min_lead) m_min_lead = m_since_csfall;
          if (m_since_mosi < m_min_setup) m_min_setup = m_since_mosi;
          m_bits = {m_bits[46:0], spi_mosi};
          m_nrise++;
        end
      end
      if (!spi_sclk && m_prev_sclk) begin
        m_since_fall = 0;
        spi_miso     = resp_bit(m_nrise);
      end
      if (!m_prev_cs && spi_cs_n) begin
        if (m_since_fall < m_min_lag) m_min_lag = m_since_fall;
        txq.push_back('{m_bits, m_nrise});
        m_since_csrise = 0;
      end
      if (sample_valid) begin
        m_nvalid++;
        m_last_lat = m_since_csrise;
      end
      m_prev_cs   = spi_cs_n;
      m_prev_sclk = spi_sclk;
      m_prev_mosi = spi_mosi;
    end
  end

  // ---------------- CS-high gap monitor (short-period instance) ------------
  logic b_prev_cs = 1'b1, b_seen_rise = 1'b0;
  int   b_high = 0, b_min = 1000000, b_max = 0, b_ntx = 0, b_nvalid = 0;

  always @(negedge clk) begin
    if (!rst_b) begin
      if (!b_prev_cs && b_cs_n) begin
        b_high      = 1;
        b_seen_rise = 1'b1;
        b_ntx++;
      end else if (b_cs_n) b_high++;
      if (b_prev_cs && !b_cs_n && b_seen_rise) begin
        if (b_high < b_min) b_min = b_high;
        if (b_high > b_max) b_max = b_high;
      end
      if (b_valid) b_nvalid++;
    end
    b_prev_cs = b_cs_n;
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic [7:0] xl, xh, yl, yh;
    logic [8:0] ex, ey;
  } vec_t;

  task automatic load_resp(input vec_t v);
    resp[0] = 8'hA5;
    resp[1] = 8'h5A;
    resp[2] = v.xl;
    resp[3] = v.xh;
    resp[4] = v.yl;
    resp[5] = v.yh;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk); #1;
      if (sample_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_txq(input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk); #1;
      if (txq.size() != 0) begin ok = 1'b1; break; end
    end
  endtask

  // Pops one transaction and checks its MOSI content and SCLK edge count.
  task automatic check_txn(input string tag, input logic [47:0] exp_bits, input int exp_rise);
    txn_t t;
    check({tag, "_txn_present"}, txq.size() != 0, 1);
    if (txq.size() != 0) begin
      t = txq.pop_front();
      check({tag, "_mosi_bytes"}, t.bits, exp_bits);
      check({tag, "_sclk_rises"}, t.nrise, exp_rise);
    end
  endtask

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    bit ok;
    int nv0;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 9'd256, 9'd256};
    vecs[1] = '{8'hE8, 8'h03, 8'h18, 8'h0C, 9'd381, 9'd131};
    vecs[2] = '{8'hE8, 8'hF3, 8'h18, 8'h5C, 9'd381, 9'd131};
    vecs[3] = '{8'h08, 8'h00, 8'hFF, 8'hFF, 9'd257, 9'd255};
    vecs[4] = '{8'h07, 8'hA0, 8'hF8, 8'h0F, 9'd256, 9'd255};
    vecs[5] = '{8'hFF, 8'h07, 8'h00, 8'h08, 9'd511, 9'd0};

    load_resp(vecs[0]);
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_accel_x", accel_x, 256);
    check("rst_accel_y", accel_y, 256);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);

    @(negedge clk); #2;
    rst = 1'b0;
    rst_b = 1'b0;

    // Power-up write.
    wait_txq(1000, ok);
    check("init_seen", ok, 1);
    check_txn("init", 48'h0A2D02, 24);
    check("init_accel_x", accel_x, 256);
    check("init_accel_y", accel_y, 256);
    check("init_no_valid", m_nvalid, 0);

    // Table of burst reads.
    for (int i = 0; i < NV; i++) begin
      if (i > 0) load_resp(vecs[i]);
      wait_valid(1000, ok);
      check($sformatf("v%0d_valid_seen", i), ok, 1);
      check($sformatf("v%0d_accel_x", i), accel_x, vecs[i].ex);
      check($sformatf("v%0d_accel_y", i), accel_y, vecs[i].ey);
      check($sformatf("v%0d_latency", i), m_last_lat, 1);
      check_txn($sformatf("v%0d_read", i), 48'h0B0E_0000_0000, 48);
      @(negedge clk); #1;
      check($sformatf("v%0d_valid_width", i), sample_valid, 0);
    end

    // Abort during the third byte of a read.
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk); #1;
      if (!spi_cs_n && m_nrise >= 17) begin ok = 1'b1; break; end
    end
    check("abort_point_reached", ok, 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_accel_x", accel_x, 256);
    check("abort_accel_y", accel_y, 256);
    check("abort_valid", sample_valid, 0);
    repeat (3) @(negedge clk);
    txq.delete();
    nv0 = m_nvalid;
    @(negedge clk); #2;
    rst = 1'b0;

    wait_txq(1000, ok);
    check("reinit_seen", ok, 1);
    check_txn("reinit", 48'h0A2D02, 24);
    check("reinit_accel_x", accel_x, 256);
    check("reinit_accel_y", accel_y, 256);
    check("reinit_no_valid", m_nvalid, nv0);
    wait_valid(1000, ok);
    check("post_abort_valid_seen", ok, 1);
    check("post_abort_accel_x", accel_x, 511);
    check("post_abort_accel_y", accel_y, 0);
    check("post_abort_latency", m_last_lat, 1);
    check_txn("post_abort_read", 48'h0B0E_0000_0000, 48);

    // Protocol-wide timing properties.
    check("mosi_change_while_sclk_high", m_mosi_err, 0);
    check("sclk_rise_with_cs_high", m_sclk_err, 0);
    check("busy_vs_cs_n", m_busy_err, 0);
    check("cs_lead_ge_half", m_min_lead >= HALF, 1);
    check("cs_lag_ge_half", m_min_lag >= HALF, 1);
    check("mosi_setup_ge_half", m_min_setup >= HALF, 1);

    // Short-period instance: ticks queue, gaps stay at least 2*HALF.
    check("fast_min_gap_ge_2half", b_min >= 2 * HALF, 1);
    check("fast_gap_queued_tick", b_max <= 2 * HALF + 4, 1);
    check("fast_transactions", b_ntx >= 5, 1);
    check("fast_valids", b_nvalid >= 4, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
Name: accel_spi_reader

Overview:
- Produces the tilt samples that the ball-motion logic consumes on its accelX_IN/accelY_IN inputs.
- Acts as SPI master to the on-board ADXL362 accelerometer. After reset it places the sensor in measurement mode, then periodically burst-reads X/Y data.
- Converts each axis to 9-bit offset-binary, where 256 means level. A one-cycle strobe marks each new sample pair.

Parameters:
- CLK_FREQUENCY_HZ, 100000000, system clock frequency.
- SCLK_FREQUENCY_HZ, 1000000, SPI clock rate. Half-period count HALF = CLK_FREQUENCY_HZ/(2*SCLK_FREQUENCY_HZ); HALF must be ≥ 2.
- SAMPLE_FREQUENCY_HZ, 100, read-transaction start rate.
- SIMULATE, 0. When 1, the sample period is SIMULATE_SAMPLE_CNT+1 clocks.
- SIMULATE_SAMPLE_CNT, 2000. Must exceed the worst-case transaction length.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- spi_sclk, out, 1, SPI clock, mode 0 (idles low).
- spi_mosi, out, 1, master data out.
- spi_miso, in, 1, slave data in.
- spi_cs_n, out, 1, chip select, active-low.
- accel_x, out, 9, X tilt, offset-binary.
- accel_y, out, 9, Y tilt, offset-binary.
- sample_valid, out, 1, one-clock pulse when accel_x/accel_y update.
- busy, out, 1, high while spi_cs_n is low.

Behaviour:
- Reset values (asserted asynchronously):
  - accel_x = accel_y = 9'd256; sample_valid = 0; busy = 0.
  - spi_cs_n = 1; spi_sclk = 0; spi_mosi = 0.
  - FSM = INIT; all counters cleared.
- Reset asserted mid-transaction aborts it immediately. The partial transaction is discarded, outputs are not updated, and INIT reruns after release.
- SPI mode 0:
  - MOSI is driven MSB-first, set up ≥ HALF clocks before each rising SCLK edge.
  - MISO is sampled in the clk cycle in which spi_sclk rises.
  - MOSI changes only while SCLK is low.
  - spi_cs_n falls ≥ HALF clocks before the first rising edge and rises ≥ HALF clocks after the last falling edge.
  - Between transactions spi_cs_n stays high for ≥ 2*HALF clocks.
- Sample tick:
  - Free-running counter wraps at CLK_FREQUENCY_HZ/SAMPLE_FREQUENCY_HZ − 1, or at SIMULATE_SAMPLE_CNT when SIMULATE = 1.
  - A tick that arrives while busy or in INIT is latched as pending (depth 1). Further ticks while pending are dropped.
- FSM states:
  - INIT: one write transaction of bytes 0x0A, 0x2D, 0x02 (POWER_CTL := measure) → IDLE.
  - IDLE: on tick or pending → READ.
  - READ: bytes 0x0B, 0x0E, then 4 dummy 0x00 bytes. MISO bytes 3..6 are captured as XL, XH, YL, YH → CONVERT.
  - CONVERT (1 clk): updates outputs, pulses sample_valid → IDLE.
- Conversion, per axis:
  - s12 = {H[3:0], L} (12-bit two's complement; H[7:4] ignored).
  - out = {~s12[11], s12[10:3]}, i.e. s12/8 + 256 with truncation.
  - This gives 0..511 for −2048..+2047 mg.
- Latency: sample_valid asserts exactly one clk after spi_cs_n rises at the end of READ.
- Both axes update in the same cycle, so there is no torn pair.
- busy = ~spi_cs_n.

Decomposition:
- Shared package accel_pkg holds:
  - command constants CMD_WRITE = 8'h0A, CMD_READ = 8'h0B;
  - register addresses REG_XDATA_L = 8'h0E, REG_POWER_CTL = 8'h2D;
  - PWR_MEASURE = 8'h02;
  - MID_SCALE = 9'd256;
  - the FSM state enum.
- One sub-module, spi_byte_shifter, handles a single byte:
  - interface: start, tx_byte[7:0] in; rx_byte[7:0], done out;
  - owns the SCLK half-period divider and the 8-bit shift registers.
- The top level sequences bytes and controls spi_cs_n.

Test Plan:
- Reset release → first transaction MOSI = 0x0A, 0x2D, 0x02 over 24 SCLK rising edges with spi_cs_n low throughout; accel_x = accel_y = 256 and no sample_valid until the first READ completes.
- Slave model returns XL = 0x00, XH = 0x00, YL = 0x00, YH = 0x00 → accel_x = accel_y = 256, one sample_valid pulse exactly 1 clk after spi_cs_n rises.
- Slave returns XL = 0xE8, XH = 0x03 (+1000) and YL = 0x18, YH = 0x0C (−1000, with junk ignored in H[7:4]) → accel_x = 381, accel_y = 131.
- Extremes: X = 0x7FF, Y = 0x800 → accel_x = 511, accel_y = 0. Check every MOSI transition occurs while SCLK is low and every read starts with bytes 0x0B, 0x0E.
- Assert reset at the 3rd byte of a READ → spi_cs_n high and spi_sclk low in the same cycle, outputs stay 256, and INIT repeats after release.
- Force SIMULATE_SAMPLE_CNT smaller than the transaction length → ticks are queued (one pending) and spi_cs_n-high gaps are always ≥ 2*HALF clocks.
